levinson_k_seq: RTL and testbench

Parametrised, handshaked reflection-coefficient unit for the Levinson-Durbin recursion: computes k = -(q · 2^K_SHIFT) / e with its own iterative restoring divider, so no vendor divide megafunction is needed. Sits between the error/accumulator update stage (supplies e and q) and the predictor-coefficient update stage (consumes k). Adds configurable widths, configurable radix, overflow/divide-by-zero detection and optional saturation.

---
 rtl/levinson_k_pkg.sv | 18 +
 rtl/levinson_k_div_step.sv | 28 ++
 rtl/levinson_k_seq.sv | 115 +++++++++++
 tb/tb_levinson_k_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/levinson_k_pkg.sv
// levinson_k_pkg: shared FSM state type and elaboration helpers for levinson_k_seq
package levinson_k_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int quot_bits(input int q_w, input int k_shift);
        return q_w + k_shift;
    endfunction

    function automatic bit steps_legal(input int steps, input int n);
        return (steps == 1 || steps == 2 || steps == 4) && (n % steps == 0);
    endfunction

endpackage

// File: rtl/levinson_k_div_step.sv
// levinson_k_div_step: combinational STEPS-bit restoring division step, MSB first
module levinson_k_div_step
    import levinson_k_pkg::*;
#(
    parameter int E_W   = 32,
    parameter int STEPS = 1
) (
    input  logic [E_W-1:0]   rem,
    input  logic [E_W-1:0]   div,
    input  logic [STEPS-1:0] bits,
    output logic [E_W-1:0]   rem_next,
    output logic [STEPS-1:0] qbits
);

    logic [E_W:0] r;

    always_comb begin
        r = {1'b0, rem};
        qbits = '0;
        for (int i = STEPS - 1; i >= 0; i--) begin
            r = {r[E_W-1:0], bits[i]};
            qbits[i] = r >= {1'b0, div};
            r = qbits[i] ? r - {1'b0, div} : r;
        end
        rem_next = r[E_W-1:0];
    end

endmodule

// File: rtl/levinson_k_seq.sv
// levinson_k_seq: k = -(q << K_SHIFT) / e via iterative restoring divide; LEVINSON_K_SAT_EN enables clamping
module levinson_k_seq
    import levinson_k_pkg::*;
#(
    parameter int Q_W     = 32,
    parameter int E_W     = 32,
    parameter int K_W     = 32,
    parameter int K_SHIFT = 32,
    parameter int STEPS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [E_W-1:0] e,
    input  logic [Q_W-1:0] q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K_W-1:0] k,
    output logic           sat,
    output logic           div0
);

    localparam int N  = quot_bits(Q_W, K_SHIFT);
    localparam int NS = N / STEPS;
    localparam int CW = NS > 1 ? $clog2(NS) : 1;
    localparam int MW = (N > K_W ? N : K_W) + 1;

    if (!steps_legal(STEPS, N)) begin : g_bad_steps
        $error("STEPS must be 1, 2 or 4 and divide Q_W+K_SHIFT");
    end

    state_t         state;
    logic [E_W-1:0] e_r, rem, rem_nx;
    logic [N-1:0]   dq, dq_nx;
    logic [STEPS-1:0] qbits;
    logic [CW-1:0]  cnt;
    logic [Q_W-1:0] q_abs;
    logic [MW-1:0]  mag, lim;
    logic [K_W-1:0] k_fin, k_zero;
    logic           neg, neg_in, qnz, over;

    // dq holds the unconsumed dividend on top and the growing quotient below it
    levinson_k_div_step #(.E_W(E_W), .STEPS(STEPS)) u_step (
        .rem      (rem),
        .div      (e_r),
        .bits     (dq[N-1 -: STEPS]),
        .rem_next (rem_nx),
        .qbits    (qbits)
    );

    function automatic logic [K_W-1:0] clamp_of(input logic n);
        return n ? {1'b1, {(K_W-1){1'b0}}} : {1'b0, {(K_W-1){1'b1}}};
    endfunction

    always_comb begin
        q_abs = q[Q_W-1] ? -q : q;
        qnz = |q;
        neg_in = ~q[Q_W-1] & qnz;
        dq_nx = (dq << STEPS) | N'(qbits);
        mag = MW'(dq_nx);
        lim = MW'(1) << (K_W - 1);
        over = neg ? mag > lim : mag >= lim;
`ifdef LEVINSON_K_SAT_EN
        k_fin = over ? clamp_of(neg) : (neg ? -mag[K_W-1:0] : mag[K_W-1:0]);
        k_zero = qnz ? clamp_of(neg_in) : '0;
`else
        k_fin = neg ? -mag[K_W-1:0] : mag[K_W-1:0];
        k_zero = '0;
`endif
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            e_r   <= '0;
            rem   <= '0;
            dq    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            k     <= '0;
            sat   <= 1'b0;
            div0  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                e_r   <= e;
                rem   <= '0;
                dq    <= N'(q_abs) << K_SHIFT;
                cnt   <= '0;
                neg   <= neg_in;
                div0  <= ~|e;
                state <= ~|e ? DONE : CALC;
                if (~|e) begin
                    k   <= k_zero;
                    sat <= qnz;
                end
            end
        end else if (state == CALC) begin
            dq  <= dq_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(NS - 1)) begin
                state <= DONE;
                k     <= k_fin;
                sat   <= over;
            end
        end else if (out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_levinson_k_seq.sv
// tb_levinson_k_seq: directed checks of levinson_k_seq at STEPS=1, 2 and 4
module tb_levinson_k_seq;

`ifdef LEVINSON_K_SAT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] e = '0, q = '0;
    logic        ir1, ov1, s1, d1, ir2, ov2, s2, d2, ir4, ov4, s4, d4;
    logic [31:0] k1, k2, k4;
    int          checks = 0, passed = 0;
    int          l1, l2, l4;

    always #5 clk = ~clk;

    levinson_k_seq #(.STEPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .e(e), .q(q),
        .out_valid(ov1), .out_ready(out_ready), .k(k1), .sat(s1), .div0(d1)
    );
    levinson_k_seq #(.STEPS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .e(e), .q(q),
        .out_valid(ov2), .out_ready(out_ready), .k(k2), .sat(s2), .div0(d2)
    );
    levinson_k_seq #(.STEPS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .e(e), .q(q),
        .out_valid(ov4), .out_ready(out_ready), .k(k4), .sat(s4), .div0(d4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // latency counts the acceptance edge as edge 1
    task automatic op(input logic [31:0] ee, input logic [31:0] qq);
        int n = 0;
        @(negedge clk);
        e = ee;
        q = qq;
        in_valid = 1'b1;
        l1 = 0; l2 = 0; l4 = 0;
        while (l1 == 0 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) in_valid = 1'b0;
            if (ov1 && l1 == 0) l1 = n;
            if (ov2 && l2 == 0) l2 = n;
            if (ov4 && l4 == 0) l4 = n;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid after take", {63'b0, ov1}, 64'd0);
        chk("in_ready after take", {63'b0, ir1}, 64'd1);
    endtask

    task automatic res(input string tag, input logic [31:0] ek, input logic es, input logic ed, input int el);
        chk({tag, " k"}, {32'b0, k1}, {32'b0, ek});
        chk({tag, " sat"}, {63'b0, s1}, {63'b0, es});
        chk({tag, " div0"}, {63'b0, d1}, {63'b0, ed});
        chk({tag, " latency"}, 64'(l1), 64'(el));
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {63'b0, ir1}, 64'd1);
        chk("reset out_valid", {63'b0, ov1}, 64'd0);
        chk("reset k", {32'b0, k1}, 64'd0);
        chk("reset sat", {63'b0, s1}, 64'd0);
        chk("reset div0", {63'b0, d1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle out_ready in_ready", {63'b0, ir1}, 64'd1);
        chk("idle out_ready out_valid", {63'b0, ov1}, 64'd0);

        op(32'h8000_0000, 32'h2000_0000);
        res("pos q", 32'hC000_0000, 1'b0, 1'b0, 65);
        chk("steps2 k", {32'b0, k2}, 64'hC000_0000);
        chk("steps2 latency", 64'(l2), 64'd33);
        chk("steps4 k", {32'b0, k4}, 64'hC000_0000);
        chk("steps4 latency", 64'(l4), 64'd17);

        // producer holds a new request while the result sits unconsumed
        @(negedge clk);
        e = 32'd7;
        q = 32'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", {63'b0, ov1}, 64'd1);
            chk("hold in_ready", {63'b0, ir1}, 64'd0);
            chk("hold k", {32'b0, k1}, 64'hC000_0000);
            chk("hold sat", {63'b0, s1}, 64'd0);
            chk("hold div0", {63'b0, d1}, 64'd0);
        end
        in_valid = 1'b0;
        take();

        op(32'h8000_0000, 32'hE000_0000);
        res("neg q", 32'h4000_0000, 1'b0, 1'b0, 65);
        take();

        op(32'd3, 32'd1);
        res("trunc", 32'hAAAA_AAAB, 1'b0, 1'b0, 65);
        take();

        @(negedge clk);
        e = 32'd3;
        q = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midcalc reset in_ready", {63'b0, ir1}, 64'd1);
        chk("midcalc reset out_valid", {63'b0, ov1}, 64'd0);
        chk("midcalc reset k", {32'b0, k1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            seen |= int'(ov1);
        end
        chk("no output after reset", 64'(seen), 64'd0);

        op(32'h4000_0000, 32'h4000_0000);
        res("sat neg", SE ? 32'h8000_0000 : 32'h0, 1'b1, 1'b0, 65);
        take();

        op(32'h4000_0000, 32'hC000_0000);
        res("sat pos", SE ? 32'h7FFF_FFFF : 32'h0, 1'b1, 1'b0, 65);
        take();

        op(32'h8000_0000, 32'h8000_0000);
        res("q min", SE ? 32'h7FFF_FFFF : 32'h0, 1'b1, 1'b0, 65);
        take();

        op(32'd0, 32'd5);
        res("div0 q5", SE ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, 1);
        take();

        op(32'd0, 32'd0);
        res("div0 q0", 32'h0, 1'b0, 1'b1, 1);
        take();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
